// File: rtl/obstacle_level_controller_pkg.sv
// Shared definitions for the obstacle-lane game controller:
//   - game state encoding (also exported on the debug/HUD state output)
//   - score thresholds that select the obstacle speed tier
//   - playfield geometry constants shared with the video side
package obstacle_level_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_HOLD      = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  // Highest score that still belongs to tiers 0, 1 and 2.
  localparam int unsigned TIER0_MAX_SCORE = 3;
  localparam int unsigned TIER1_MAX_SCORE = 6;
  localparam int unsigned TIER2_MAX_SCORE = 9;

  localparam int unsigned TILE_SIZE      = 32;
  localparam int unsigned H_VISIBLE_AREA = 640;

  // Right-shift applied to the base tick period for a given score.
  function automatic logic [1:0] speed_shift(input logic [6:0] score);
    if (score <= 7'(TIER0_MAX_SCORE)) return 2'd0;
    if (score <= 7'(TIER1_MAX_SCORE)) return 2'd1;
    if (score <= 7'(TIER2_MAX_SCORE)) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/obstacle_level_controller_if.sv
// Game-flow bundle between the frog/collision logic, the controller and the
// obstacle movement datapath.
//   i_Start, i_Goal_Reached, i_Collision : requests into the controller
//   o_Score, o_Lives, o_Reverse, o_Level_Up, o_Car_Speed, o_Move_Tick,
//   o_Freeze, o_Game_Over, o_State        : registered controller outputs
// slave  = controller side, master = driver/observer side.
interface obstacle_level_controller_if
  import obstacle_level_controller_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4
);
  logic                 i_Start;
  logic                 i_Goal_Reached;
  logic                 i_Collision;
  logic [6:0]           o_Score;
  logic [1:0]           o_Lives;
  logic [NUM_LANES-1:0] o_Reverse;
  logic                 o_Level_Up;
  logic [19:0]          o_Car_Speed;
  logic                 o_Move_Tick;
  logic                 o_Freeze;
  logic                 o_Game_Over;
  state_e               o_State;

  modport master (
    output i_Start, i_Goal_Reached, i_Collision,
    input  o_Score, o_Lives, o_Reverse, o_Level_Up, o_Car_Speed,
    input  o_Move_Tick, o_Freeze, o_Game_Over, o_State
  );

  modport slave (
    input  i_Start, i_Goal_Reached, i_Collision,
    output o_Score, o_Lives, o_Reverse, o_Level_Up, o_Car_Speed,
    output o_Move_Tick, o_Freeze, o_Game_Over, o_State
  );
endinterface

// File: rtl/obstacle_level_controller_level_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4, maximal length) used to
// pick new lane directions on each level-up. Never reaches zero from a
// non-zero seed.
//   i_Clk   : system clock
//   i_Rst_N : asynchronous active-low reset, loads SEED
//   o_Lfsr  : current LFSR value
module level_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  output logic [7:0] o_Lfsr
);
  logic [7:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign o_Lfsr = lfsr_q;
endmodule

// File: rtl/obstacle_level_controller.sv
// Game-flow scheduler for the obstacle lanes: owns score, lives and level
// progression, selects the speed tier, and generates the shared movement tick.
//   i_Clk, i_Rst_N : system clock, asynchronous active-low reset
//   bus (slave)    : start/goal/collision in; score, lives, lane directions,
//                    level-up strobe, tick period, move tick, freeze,
//                    game-over and state out (all registered)
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | waiting for start, everything frozen
// ST_PLAY      | obstacles move, goal/collision pulses are acted on
// ST_LEVEL_UP  | single cycle, new lane directions strobed out
// ST_HOLD      | freeze for c_HOLD_CYCLES after a collision or level-up
// ST_GAME_OVER | lives exhausted, waits for start
module obstacle_level_controller
  import obstacle_level_controller_pkg::*;
#(
  parameter int unsigned          NUM_LANES        = 4,
  parameter int unsigned          c_BASE_CAR_SPEED = 781250,
  parameter int unsigned          c_START_LIVES    = 3,
  parameter int unsigned          c_MAX_SCORE      = 99,
  parameter int unsigned          c_HOLD_CYCLES    = 12500000,
  parameter logic [NUM_LANES-1:0] c_INIT_REVERSE   = 4'b1010,
  parameter logic [7:0]           c_LFSR_SEED      = 8'hA5
) (
  input logic                   i_Clk,
  input logic                   i_Rst_N,
  obstacle_level_controller_if.slave bus
);
  localparam int unsigned HOLD_W = $clog2(c_HOLD_CYCLES) + 1;

  state_e               state_q, state_d;
  logic [6:0]           score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic [NUM_LANES-1:0] reverse_q, reverse_d, lane_pick;
  logic                 level_up_q, level_up_d;
  logic [19:0]          speed_q, speed_d;
  logic [19:0]          tick_cnt_q, tick_cnt_d;
  logic                 move_tick_q, move_tick_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 freeze_q, freeze_d;
  logic                 game_over_q, game_over_d;
  logic [7:0]           lfsr;

  level_lfsr #(.SEED(c_LFSR_SEED)) u_lfsr (
    .i_Clk  (i_Clk),
    .i_Rst_N(i_Rst_N),
    .o_Lfsr (lfsr)
  );

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    reverse_d   = reverse_q;
    tick_cnt_d  = tick_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    level_up_d  = 1'b0;
    move_tick_d = 1'b0;

    // An all-zero mask would send every lane the same way; fall back to the
    // mirror of the start pattern instead.
    lane_pick = lfsr[NUM_LANES-1:0];
    if (lane_pick == '0) lane_pick = ~c_INIT_REVERSE;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_Start) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          lives_d    = 2'(c_START_LIVES);
          reverse_d  = c_INIT_REVERSE;
          tick_cnt_d = '0;
        end
      end
      ST_PLAY: begin
        // Collision has priority; a simultaneous goal is dropped.
        if (bus.i_Collision) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_HOLD;
        end else if (bus.i_Goal_Reached) begin
          score_d    = (score_q >= 7'(c_MAX_SCORE)) ? 7'(c_MAX_SCORE) : score_q + 7'd1;
          reverse_d  = lane_pick;
          level_up_d = 1'b1;
          state_d    = ST_LEVEL_UP;
        end
        // >= rather than == so a period that shrinks mid-count still fires.
        if (tick_cnt_q >= speed_q - 20'd1) begin
          tick_cnt_d  = '0;
          move_tick_d = (state_d == ST_PLAY);
        end else begin
          tick_cnt_d = tick_cnt_q + 20'd1;
        end
      end
      ST_LEVEL_UP: begin
        tick_cnt_d = '0;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(c_HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = ST_PLAY;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_GAME_OVER: begin
        if (bus.i_Start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    freeze_d    = (state_d != ST_PLAY);
    game_over_d = (state_d == ST_GAME_OVER);
    // Tier follows the registered score, so it lags a score change by a cycle.
    speed_d     = 20'(c_BASE_CAR_SPEED) >> speed_shift(score_q);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      lives_q     <= 2'(c_START_LIVES);
      reverse_q   <= c_INIT_REVERSE;
      level_up_q  <= 1'b0;
      speed_q     <= 20'(c_BASE_CAR_SPEED);
      tick_cnt_q  <= '0;
      move_tick_q <= 1'b0;
      hold_cnt_q  <= '0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      reverse_q   <= reverse_d;
      level_up_q  <= level_up_d;
      speed_q     <= speed_d;
      tick_cnt_q  <= tick_cnt_d;
      move_tick_q <= move_tick_d;
      hold_cnt_q  <= hold_cnt_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.o_Score     = score_q;
  assign bus.o_Lives     = lives_q;
  assign bus.o_Reverse   = reverse_q;
  assign bus.o_Level_Up  = level_up_q;
  assign bus.o_Car_Speed = speed_q;
  assign bus.o_Move_Tick = move_tick_q;
  assign bus.o_Freeze    = freeze_q;
  assign bus.o_Game_Over = game_over_q;
  assign bus.o_State     = state_q;
endmodule
